// File: rtl/sram_ctrl_pkg.sv
// Shared types for the SRAM controller: access-size and FSM state enums plus
// small helpers for byte masks and sub-word alignment.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RDWAIT = 2'd1,
    RESP   = 2'd2
  } state_e;

  function automatic logic [3:0] size_mask(size_e size);
    case (size)
      SZ_BYTE: return 4'b0001;
      SZ_HALF: return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Offset with the bits below the access size cleared.
  function automatic logic [1:0] align_off(size_e size, logic [1:0] off);
    case (size)
      SZ_BYTE: return off;
      SZ_HALF: return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic misaligned(size_e size, logic [1:0] off);
    case (size)
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sram_ctrl_fmt.sv
// Combinational data formatting: store byte-enables and lane replication,
// load lane extraction with zero/sign extension.
module sram_ctrl_fmt
  import sram_ctrl_pkg::*;
(
  input  size_e       st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_byte_en_o,
  output logic [31:0] st_wdata_o,
  input  size_e       ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_raw_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] shifted;

  always_comb begin
    st_byte_en_o = size_mask(st_size_i) << st_off_i;
    // Replicating the datum into every lane lets the byte-enables pick the lane.
    case (st_size_i)
      SZ_BYTE: st_wdata_o = {4{st_wdata_i[7:0]}};
      SZ_HALF: st_wdata_o = {2{st_wdata_i[15:0]}};
      default: st_wdata_o = st_wdata_i;
    endcase

    shifted = ld_raw_i >> {ld_off_i, 3'b000};
    case (ld_size_i)
      SZ_BYTE: ld_data_o = {{24{~ld_unsigned_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: ld_data_o = {{16{~ld_unsigned_i & shifted[15]}}, shifted[15:0]};
      default: ld_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/sram_ctrl.sv
// CPU-to-SRAM load/store controller with one outstanding access.
// Define SRAM_CTRL_MISALIGN_TRAP_EN to fault misaligned accesses instead of aligning them.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter  int DEPTH    = 1024,
  localparam int LOGDEPTH = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [31:0]         req_addr,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [31:0]         req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [31:0]         resp_rdata,
  output logic                resp_error,
  output logic                sram_read_req,
  output logic [LOGDEPTH-1:0] sram_read_addr,
  input  logic [31:0]         sram_read_data,
  output logic                sram_write_req,
  output logic [LOGDEPTH-1:0] sram_write_addr,
  output logic [3:0]          sram_write_byte_en,
  output logic [31:0]         sram_write_data
);

  state_e      state_q;
  size_e       size_q;
  logic [1:0]  off_q;
  logic        uns_q;
  logic [31:0] rdata_q;
  logic        error_q;

  size_e       size_d;
  logic [1:0]  off_d;
  logic        misalign;
  logic        fault;
  logic        accept;
  logic [31:0] ld_data;

  assign size_d    = size_e'(req_size);
  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  always_comb begin
`ifdef SRAM_CTRL_MISALIGN_TRAP_EN
    misalign = misaligned(size_d, req_addr[1:0]);
    off_d    = req_addr[1:0];
`else
    misalign = 1'b0;
    off_d    = align_off(size_d, req_addr[1:0]);
`endif
    fault = (size_d == SZ_RSVD) || ({2'b00, req_addr[31:2]} >= 32'(DEPTH)) || misalign;
  end

  // Requests are issued in the accept cycle itself; req_ready already masks reset.
  assign sram_read_req   = accept && !req_write && !fault;
  assign sram_write_req  = accept && req_write && !fault;
  assign sram_read_addr  = req_addr[LOGDEPTH+1:2];
  assign sram_write_addr = req_addr[LOGDEPTH+1:2];

  sram_ctrl_fmt u_fmt (
    .st_size_i     (size_d),
    .st_off_i      (off_d),
    .st_wdata_i    (req_wdata),
    .st_byte_en_o  (sram_write_byte_en),
    .st_wdata_o    (sram_write_data),
    .ld_size_i     (size_q),
    .ld_off_i      (off_q),
    .ld_unsigned_i (uns_q),
    .ld_raw_i      (sram_read_data),
    .ld_data_o     (ld_data)
  );

  // NOTE: state is updated with non-blocking assignments only, so every
  // branch sees the pre-edge values; all registers here are small control
  // and response flops, so each one gets an explicit reset value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      size_q  <= SZ_BYTE;
      off_q   <= 2'b00;
      uns_q   <= 1'b0;
      rdata_q <= 32'h0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            size_q  <= size_d;
            off_q   <= off_d;
            uns_q   <= req_unsigned;
            rdata_q <= 32'h0;
            error_q <= fault;
            state_q <= (fault || req_write) ? RESP : RDWAIT;
          end
        end
        RDWAIT: begin
          rdata_q <= ld_data;
          state_q <= RESP;
        end
        RESP: begin
          if (resp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_error = error_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: byte-level reference memory, SRAM model,
// directed scenarios followed by randomized loads/stores.
module tb_sram_ctrl;

  localparam int DEPTH = 1024;
`ifdef SRAM_CTRL_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_error;
  logic [31:0] resp_rdata;
  logic        sram_read_req, sram_write_req;
  logic [9:0]  sram_read_addr, sram_write_addr;
  logic [31:0] sram_read_data, sram_write_data;
  logic [3:0]  sram_write_byte_en;
  logic        mem_clear;

  always #5 clk = ~clk;

  sram_ctrl #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_write         (req_write),
    .req_addr          (req_addr),
    .req_size          (req_size),
    .req_unsigned      (req_unsigned),
    .req_wdata         (req_wdata),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_rdata        (resp_rdata),
    .resp_error        (resp_error),
    .sram_read_req     (sram_read_req),
    .sram_read_addr    (sram_read_addr),
    .sram_read_data    (sram_read_data),
    .sram_write_req    (sram_write_req),
    .sram_write_addr   (sram_write_addr),
    .sram_write_byte_en(sram_write_byte_en),
    .sram_write_data   (sram_write_data)
  );

  // SRAM model: synchronous write with byte enables, one-cycle read latency.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else begin
      if (sram_write_req)
        for (int b = 0; b < 4; b++)
          if (sram_write_byte_en[b]) mem[sram_write_addr][8*b +: 8] <= sram_write_data[8*b +: 8];
      if (sram_read_req) sram_read_data <= mem[sram_read_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: byte-addressed memory and a queue of expected responses.
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  logic [7:0] ref_mem [4*DEPTH];
  exp_t       sb[$];

  task automatic send(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                      input bit uns, input logic [31:0] wd, input bit push);
    int          n;
    int          waited;
    bit          flt;
    logic [31:0] a, val, wmask, wexp;
    logic [3:0]  be;
    exp_t        e;
    n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    flt = (size == 2'd3) || (addr[31:2] >= 30'(DEPTH)) || (TRAP && (int'(addr[1:0]) % n) != 0);
    a   = TRAP ? addr : (addr & ~(32'(n - 1)));
    val = 32'h0; wmask = 32'h0; wexp = 32'h0; be = 4'h0;
    if (!flt) begin
      for (int i = 0; i < n; i++) begin
        int bi;
        bi = int'(a[1:0]) + i;
        be[bi] = 1'b1;
        wmask[8*bi +: 8] = 8'hFF;
        wexp[8*bi +: 8]  = wd[8*i +: 8];
        if (wr) ref_mem[a + 32'(i)] = wd[8*i +: 8];
        else    val[8*i +: 8] = ref_mem[a + 32'(i)];
      end
      if (!wr && !uns && n == 1 && val[7])  val[31:8]  = 24'hFFFFFF;
      if (!wr && !uns && n == 2 && val[15]) val[31:16] = 16'hFFFF;
    end
    e.rdata = (flt || wr) ? 32'h0 : val;
    e.err   = flt;
    e.lat   = (flt || wr) ? 1 : 2;

    req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wd;
    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("req_ready", 32'(req_ready), 32'd1);
    e.acc = cyc;
    check("sram_read_req", 32'(sram_read_req), 32'(!wr && !flt));
    check("sram_write_req", 32'(sram_write_req), 32'(wr && !flt));
    if (!flt && wr) begin
      check("write_addr", 32'(sram_write_addr), 32'(a[11:2]));
      check("byte_en", 32'(sram_write_byte_en), 32'(be));
      check("write_data", sram_write_data & wmask, wexp);
    end
    if (!flt && !wr) check("read_addr", 32'(sram_read_addr), 32'(a[11:2]));
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = $urandom; req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_wdata = $urandom;
  endtask

  task automatic wait_resp(input int stall);
    int waited;
    waited = 0;
    if (stall > 0) begin
      resp_ready = 1'b0;
      repeat (stall) begin
        @(negedge clk);
        check("stall_req_ready", 32'(req_ready), 32'd0);
        check("stall_read_req", 32'(sram_read_req), 32'd0);
        check("stall_write_req", 32'(sram_write_req), 32'd0);
      end
      resp_ready = 1'b1;
    end else begin
      @(negedge clk);
    end
    while (!resp_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("resp_timeout", 32'(resp_valid), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic access(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                        input bit uns, input logic [31:0] wd, input int stall);
    send(wr, addr, size, uns, wd, 1'b1);
    wait_resp(stall);
  endtask

  // Monitor: pops one expectation per response and checks it holds until taken.
  exp_t        cur;
  bit          prev_valid = 1'b0;
  bit          prev_hs = 1'b0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (prev_valid && !prev_hs) begin
        check("resp_hold", 32'(resp_valid), 32'd1);
        check("rdata_hold", resp_rdata, cur.rdata);
        check("error_hold", 32'(resp_error), 32'(cur.err));
      end else if (resp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 32'(resp_valid), 32'd0);
        end else begin
          cur = sb.pop_front();
          check("latency", 32'(cyc - cur.acc), 32'(cur.lat));
          check("rdata", resp_rdata, cur.rdata);
          check("error", 32'(resp_error), 32'(cur.err));
          last_rdata = resp_rdata;
          last_err   = resp_error;
        end
      end
      prev_valid = resp_valid;
      prev_hs    = resp_valid && resp_ready;
    end
  end

  initial begin
    reset = 1'b1; mem_clear = 1'b1; resp_ready = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_size = 2'd0;
    req_unsigned = 1'b0; req_wdata = 32'h0;
    for (int i = 0; i < 4*DEPTH; i++) ref_mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1 mem_clear = 1'b0;
    @(negedge clk);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_rdata", resp_rdata, 32'h0);
    check("reset_resp_error", 32'(resp_error), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // Word store then load back.
    access(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 0);
    access(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0);
    check("word_load", last_rdata, 32'hDEADBEEF);

    // Sub-word loads with sign and zero extension.
    access(1'b1, 32'h10, 2'd2, 1'b0, 32'h80FF1234, 0);
    access(1'b0, 32'h13, 2'd0, 1'b0, 32'h0, 0);
    check("byte_signed", last_rdata, 32'hFFFFFF80);
    access(1'b0, 32'h13, 2'd0, 1'b1, 32'h0, 0);
    check("byte_unsigned", last_rdata, 32'h00000080);
    access(1'b0, 32'h12, 2'd1, 1'b0, 32'h0, 0);
    check("half_signed", last_rdata, 32'hFFFF80FF);

    // Half store into the upper lane.
    access(1'b1, 32'h12, 2'd1, 1'b0, 32'h0000ABCD, 0);
    access(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0);
    check("half_store", last_rdata, 32'hABCD1234);

    // Back-pressured load response.
    access(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 5);
    check("stalled_load", last_rdata, 32'hABCD1234);

    // Misaligned word load, out-of-range load, reserved size.
    access(1'b0, 32'h11, 2'd2, 1'b0, 32'h0, 0);
    check("misalign_error", 32'(last_err), 32'(TRAP));
    check("misalign_data", last_rdata, TRAP ? 32'h0 : 32'hABCD1234);
    access(1'b0, 32'h1000, 2'd2, 1'b0, 32'h0, 0);
    check("range_error", 32'(last_err), 32'd1);
    access(1'b0, 32'h10, 2'd3, 1'b0, 32'h0, 0);
    check("rsvd_error", 32'(last_err), 32'd1);

    // Reset while a load waits for SRAM data: the load is dropped.
    send(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 1'b0);
    reset = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_size = 2'd2;
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_read_req", 32'(sram_read_req), 32'd0);
    check("rst_write_req", 32'(sram_write_req), 32'd0);
    req_valid = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check("rst_release_ready", 32'(req_ready), 32'd1);
    repeat (6) @(negedge clk);
    @(posedge clk); #1;

    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      logic [31:0] addr;
      addr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63));
      access(1'($urandom), addr, 2'($urandom), 1'($urandom), $urandom, $urandom_range(0, 2));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
